// File: rtl/onchip_mem_arb_pkg.sv
// Shared types for the on-chip RAM arbiter: sequencer states and master ids.
package onchip_mem_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the master that did not win the
// last grant wins; an idle cycle leaves the history untouched.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic r_last_grant;
  logic w_any_req;

  assign w_any_req = |req;

  // grant decode from current requests and grant history
  always_comb begin
    gnt    = 2'b00;
    gnt_id = M0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = M0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = M1;
      end
      2'b11: begin
        if (r_last_grant == M1) begin
          gnt    = 2'b01;
          gnt_id = M0;
        end else begin
          gnt    = 2'b10;
          gnt_id = M1;
        end
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = M0;
      end
    endcase
  end

  // remember the winner; reset to M1 so M0 takes the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= M1;
    end else if (w_any_req) begin
      r_last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM (registered address, unregistered
// output) between two Avalon-MM masters. One access per cycle, round-robin
// on ties, read data returned one cycle after the grant. Optionally
// zero-fills the RAM after reset before any master is admitted.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_INIT | writing zero to r_clr_addr each cycle; both masters stalled
// ST_RUN  | normal arbitration between m0 and m1
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = {ADDR_W{1'b1}};
  localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                r_rd_vld;
  logic                r_rd_id;

  logic                w_req0;
  logic                w_req1;
  logic                w_run;
  logic [1:0]          w_arb_req;
  logic [1:0]          w_gnt;
  logic                w_gnt_id;
  logic                w_any_gnt;
  logic                w_sel_read;
  logic                w_sel_write;
  logic                w_rd_grant;

  // A simultaneous read and write is taken as a write.
  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Arbitration is suppressed in reset and during the zero-fill.
  assign w_run     = (r_state == ST_RUN) && !reset;
  assign w_arb_req = w_run ? {w_req1, w_req0} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req    (w_arb_req),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign w_any_gnt   = |w_gnt;
  assign w_sel_write = (w_gnt_id == M1) ? m1_write : m0_write;
  assign w_sel_read  = (w_gnt_id == M1) ? m1_read  : m0_read;
  assign w_rd_grant  = w_any_gnt && w_sel_read && !w_sel_write;

  // sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // zero-fill address counter, restarts at 0 on every reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  // next state and RAM-side mux (fill writes or the granted master)
  always_comb begin
    w_state_nxt    = r_state;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    case (r_state)
      ST_INIT: begin
        if (!reset) begin
          mem_address    = r_clr_addr;
          mem_byteenable = '1;
          mem_chipselect = 1'b1;
          mem_write      = 1'b1;
        end
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_any_gnt) begin
          mem_chipselect = 1'b1;
          mem_write      = w_sel_write;
          if (w_gnt_id == M1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
          end else begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
          end
        end
      end
      default: begin
        w_state_nxt = RESET_STATE;
      end
    endcase
  end

  // read-return pipeline: valid flag every cycle, owner id on read grants
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld <= 1'b0;
      r_rd_id  <= M0;
    end else begin
      r_rd_vld <= w_rd_grant;
      if (w_rd_grant) begin
        r_rd_id <= w_gnt_id;
      end
    end
  end

  // An idle master in ST_RUN is never stalled; everyone waits otherwise.
  assign m0_waitrequest = !w_run || (w_req0 && !w_gnt[0]);
  assign m1_waitrequest = !w_run || (w_req1 && !w_gnt[1]);

  assign m0_readdatavalid = !reset && r_rd_vld && (r_rd_id == M0);
  assign m1_readdatavalid = !reset && r_rd_vld && (r_rd_id == M1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  assign mem_clken = 1'b1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a default instance (1024 words, no clear)
// and a small zero-fill instance (16 words), each with its own RAM model.
module tb_onchip_mem_arbiter;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } mreq_t;

  typedef struct packed {
    mreq_t       m0;
    mreq_t       m1;
    logic        ew0;
    logic        ew1;
    logic        ev0;
    logic        ev1;
    logic [31:0] ed;
  } row_t;

  localparam mreq_t IDLE = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic  rst0, rst1;
  mreq_t q0, q1;
  logic  b_read;
  logic [3:0] b_addr;

  logic        w0_wait0, w0_wait1, w0_rdv0, w0_rdv1;
  logic [31:0] w0_rd0, w0_rd1;
  logic [9:0]  mem0_addr;
  logic [3:0]  mem0_be;
  logic        mem0_cs, mem0_we, mem0_clken;
  logic [31:0] mem0_wd, mem0_rdata;

  logic        b_wait0, b_wait1, b_rdv0, b_rdv1;
  logic [31:0] b_rd0, b_rd1;
  logic [3:0]  mem1_addr;
  logic [3:0]  mem1_be;
  logic        mem1_cs, mem1_we, mem1_clken;
  logic [31:0] mem1_wd, mem1_rdata;

  onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .reset(rst0),
    .m0_address(q0.addr), .m0_byteenable(q0.be), .m0_read(q0.rd), .m0_write(q0.wr),
    .m0_writedata(q0.wd), .m0_waitrequest(w0_wait0), .m0_readdata(w0_rd0),
    .m0_readdatavalid(w0_rdv0),
    .m1_address(q1.addr), .m1_byteenable(q1.be), .m1_read(q1.rd), .m1_write(q1.wr),
    .m1_writedata(q1.wd), .m1_waitrequest(w0_wait1), .m1_readdata(w0_rd1),
    .m1_readdatavalid(w0_rdv1),
    .mem_address(mem0_addr), .mem_byteenable(mem0_be), .mem_chipselect(mem0_cs),
    .mem_write(mem0_we), .mem_writedata(mem0_wd), .mem_clken(mem0_clken),
    .mem_readdata(mem0_rdata)
  );

  onchip_mem_arbiter #(.ADDR_W(4), .DATA_W(32), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(rst1),
    .m0_address(b_addr), .m0_byteenable(4'hF), .m0_read(b_read), .m0_write(1'b0),
    .m0_writedata(32'h0), .m0_waitrequest(b_wait0), .m0_readdata(b_rd0),
    .m0_readdatavalid(b_rdv0),
    .m1_address(4'h0), .m1_byteenable(4'h0), .m1_read(1'b0), .m1_write(1'b0),
    .m1_writedata(32'h0), .m1_waitrequest(b_wait1), .m1_readdata(b_rd1),
    .m1_readdatavalid(b_rdv1),
    .mem_address(mem1_addr), .mem_byteenable(mem1_be), .mem_chipselect(mem1_cs),
    .mem_write(mem1_we), .mem_writedata(mem1_wd), .mem_clken(mem1_clken),
    .mem_readdata(mem1_rdata)
  );

  function automatic logic [31:0] init0(input int i);
    return 32'(i) * 32'h9E3779B1;
  endfunction

  function automatic logic [31:0] init1(input int i);
    return 32'hA5A50001 + 32'(i);
  endfunction

  // RAM models: registered address, combinational read, byte-lane writes
  logic [31:0] ram0 [0:1023];
  logic [9:0]  ram0_areg;
  bit          ram0_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram0_loaded) begin
      for (int i = 0; i < 1024; i++) ram0[i] <= init0(i);
      ram0_loaded <= 1'b1;
    end else if (mem0_clken) begin
      if (mem0_cs && mem0_we)
        for (int k = 0; k < 4; k++)
          if (mem0_be[k]) ram0[mem0_addr][8*k +: 8] <= mem0_wd[8*k +: 8];
      ram0_areg <= mem0_addr;
    end
  end
  assign mem0_rdata = ram0[ram0_areg];

  logic [31:0] ram1 [0:15];
  logic [3:0]  ram1_areg;
  bit          ram1_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram1_loaded) begin
      for (int i = 0; i < 16; i++) ram1[i] <= init1(i);
      ram1_loaded <= 1'b1;
    end else if (mem1_clken) begin
      if (mem1_cs && mem1_we)
        for (int k = 0; k < 4; k++)
          if (mem1_be[k]) ram1[mem1_addr][8*k +: 8] <= mem1_wd[8*k +: 8];
      ram1_areg <= mem1_addr;
    end
  end
  assign mem1_rdata = ram1[ram1_areg];

  // Reference model: word array, who won last, and the read owed next cycle.
  logic [31:0] mdl [0:1023];
  logic        mdl_last;
  logic        mdl_pv;
  logic        mdl_pid;
  logic [31:0] mdl_pd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mreq_t rq(input logic [9:0] a);
    mreq_t m;
    m = '0; m.rd = 1'b1; m.addr = a; m.be = 4'hF;
    return m;
  endfunction

  function automatic mreq_t wq(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    mreq_t m;
    m = '0; m.wr = 1'b1; m.addr = a; m.be = be; m.wd = d;
    return m;
  endfunction

  function automatic mreq_t rnd();
    mreq_t m;
    m.rd   = 1'($urandom_range(0, 1));
    m.wr   = ($urandom_range(0, 3) == 0);
    m.addr = 10'($urandom_range(0, 15));
    m.be   = 4'($urandom_range(0, 15));
    m.wd   = $urandom();
    return m;
  endfunction

  // One cycle on dut0: drive, compare against the model, advance the model.
  task automatic step0(input mreq_t a, input mreq_t b);
    logic  req0, req1, has_g, g;
    mreq_t sel;
    @(negedge clk);
    rst0 = 1'b0; q0 = a; q1 = b;
    #2;
    req0  = a.rd | a.wr;
    req1  = b.rd | b.wr;
    has_g = req0 | req1;
    g     = (req0 && req1) ? ~mdl_last : req1;
    sel   = g ? b : a;
    chk("wait0", 32'(w0_wait0), 32'(req0 && !(has_g && !g)));
    chk("wait1", 32'(w0_wait1), 32'(req1 && !(has_g && g)));
    chk("rdv0", 32'(w0_rdv0), 32'(mdl_pv && !mdl_pid));
    chk("rdv1", 32'(w0_rdv1), 32'(mdl_pv && mdl_pid));
    if (mdl_pv) chk("rdata", mdl_pid ? w0_rd1 : w0_rd0, mdl_pd);
    chk("mem_cs", 32'(mem0_cs), 32'(has_g));
    if (has_g) begin
      chk("mem_addr", 32'(mem0_addr), 32'(sel.addr));
      chk("mem_we", 32'(mem0_we), 32'(sel.wr));
      mdl_pv  = !sel.wr;
      mdl_pid = g;
      mdl_pd  = mdl[sel.addr];
      if (sel.wr)
        for (int k = 0; k < 4; k++)
          if (sel.be[k]) mdl[sel.addr][8*k +: 8] = sel.wd[8*k +: 8];
      mdl_last = g;
    end else begin
      mdl_pv = 1'b0;
    end
  endtask

  task automatic reset0(input int n, input logic hold_rd);
    repeat (n) begin
      @(negedge clk);
      rst0 = 1'b1;
      q0 = hold_rd ? rq(10'd1) : IDLE;
      q1 = hold_rd ? rq(10'd2) : IDLE;
      #2;
      chk("rst_wait0", 32'(w0_wait0), 32'd1);
      chk("rst_wait1", 32'(w0_wait1), 32'd1);
      chk("rst_rdv0", 32'(w0_rdv0), 32'd0);
      chk("rst_rdv1", 32'(w0_rdv1), 32'd0);
      chk("rst_cs", 32'(mem0_cs), 32'd0);
    end
    mdl_last = 1'b1;
    mdl_pv   = 1'b0;
  endtask

  row_t tbl [17];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    q0 = IDLE; q1 = IDLE;
    b_read = 1'b0; b_addr = 4'h0;
    for (int i = 0; i < 1024; i++) mdl[i] = init0(i);
    mdl_last = 1'b1; mdl_pv = 1'b0; mdl_pid = 1'b0; mdl_pd = '0;

    tbl[0]  = '{wq(10'd5, 4'hF, 32'hDEADBEEF), IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{rq(10'd5), IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{IDLE, IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{wq(10'd9, 4'hF, 32'h11223344), IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{wq(10'd9, 4'h1, 32'h000000AA), IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{rq(10'd9), IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{IDLE, IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h112233AA};
    tbl[7]  = '{IDLE, wq(10'd20, 4'hF, 32'h00000055), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{rq(10'd5), rq(10'd9), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{rq(10'd5), rq(10'd9), 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[10] = '{rq(10'd5), rq(10'd9), 1'b0, 1'b1, 1'b0, 1'b1, 32'h112233AA};
    tbl[11] = '{rq(10'd5), rq(10'd9), 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[12] = '{IDLE, IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h112233AA};
    tbl[13] = '{IDLE, rq(10'd20), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[14] = '{IDLE, rq(10'd20), 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000055};
    tbl[15] = '{IDLE, rq(10'd20), 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000055};
    tbl[16] = '{IDLE, IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000055};

    reset0(2, 1'b1);
    chk("clr_rst_wait0", 32'(b_wait0), 32'd1);
    chk("clr_rst_wait1", 32'(b_wait1), 32'd1);

    // directed table: write/readback, byte lanes, fair sharing, single master
    for (int i = 0; i < 17; i++) begin
      step0(tbl[i].m0, tbl[i].m1);
      chk($sformatf("tbl%0d_wait0", i), 32'(w0_wait0), 32'(tbl[i].ew0));
      chk($sformatf("tbl%0d_wait1", i), 32'(w0_wait1), 32'(tbl[i].ew1));
      chk($sformatf("tbl%0d_rdv0", i), 32'(w0_rdv0), 32'(tbl[i].ev0));
      chk($sformatf("tbl%0d_rdv1", i), 32'(w0_rdv1), 32'(tbl[i].ev1));
      if (tbl[i].ev0) chk($sformatf("tbl%0d_data0", i), w0_rd0, tbl[i].ed);
      if (tbl[i].ev1) chk($sformatf("tbl%0d_data1", i), w0_rd1, tbl[i].ed);
    end

    // reset lands the cycle after an m1 read grant
    step0(IDLE, rq(10'd20));
    reset0(1, 1'b1);
    step0(rq(10'd5), rq(10'd9));
    chk("post_rst_rdv1", 32'(w0_rdv1), 32'd0);
    chk("post_rst_tie_m0", 32'(w0_wait0), 32'd0);
    chk("post_rst_tie_m1wait", 32'(w0_wait1), 32'd1);
    step0(IDLE, IDLE);
    chk("post_rst_data", w0_rd0, 32'hDEADBEEF);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) step0(rnd(), rnd());
    step0(IDLE, IDLE);

    // zero-fill instance: 16 stalled cycles, then everything reads zero
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      rst1 = 1'b0; b_read = 1'b1; b_addr = 4'(c);
      #2;
      chk($sformatf("fill%0d_wait0", c), 32'(b_wait0), 32'd1);
      chk($sformatf("fill%0d_wait1", c), 32'(b_wait1), 32'd1);
      chk($sformatf("fill%0d_addr", c), 32'(mem1_addr), 32'(c));
      chk($sformatf("fill%0d_wr", c), 32'(mem1_cs && mem1_we), 32'd1);
    end
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      b_read = (c < 16); b_addr = 4'(c);
      #2;
      if (c < 16) chk($sformatf("clr_rd%0d_wait0", c), 32'(b_wait0), 32'd0);
      if (c > 0) begin
        chk($sformatf("clr_rd%0d_rdv0", c - 1), 32'(b_rdv0), 32'd1);
        chk($sformatf("clr_rd%0d_rdv1", c - 1), 32'(b_rdv1), 32'd0);
        chk($sformatf("clr_rd%0d_data", c - 1), b_rd0, 32'h0);
        chk($sformatf("clr_rd%0d_data1", c - 1), b_rd1, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
